port_arbiter3: RTL and testbench

Round-robin arbiter and sequencer for a shared 32-bit 3-input datapath mux. It grants one of three requesters access to a single downstream port. It drives the mux select `sel` and the one-hot grant, and holds ownership for a multi-beat transfer until that requester's last beat is accepted. It sits between the fetch/data/debug requesters and the shared memory-side port, and its `sel` feeds the address, write-data and write-enable mux instances directly.

---
 rtl/arb_pkg.sv | 36 +++
 rtl/rr_pick3.sv | 35 +++
 rtl/port_arbiter3.sv | 132 +++++++++++++
 tb/tb_port_arbiter3.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the three-requester round-robin arbiter.
//   NREQ_C      : number of requesters (fixed at 3)
//   arb_state_t : FSM states IDLE / GRANT
//   sel_t       : 2-bit datapath mux select, values SEL_R0..SEL_R2
package arb_pkg;

    localparam int NREQ_C = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_R0 = 2'd0;
    localparam sel_t SEL_R1 = 2'd1;
    localparam sel_t SEL_R2 = 2'd2;

    // Requester index + 1, wrapping 2 -> 0 (3 is never produced).
    function automatic sel_t inc_mod3(input sel_t v);
        return (v == SEL_R2) ? SEL_R0 : sel_t'(v + 2'd1);
    endfunction

    function automatic logic [NREQ_C-1:0] onehot3(input sel_t v);
        logic [NREQ_C-1:0] oh;
        case (v)
            SEL_R0:  oh = 3'b001;
            SEL_R1:  oh = 3'b010;
            SEL_R2:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters.
//   req_i   : request vector
//   ptr_i   : first requester to consider; search order ptr, ptr+1, ptr+2 (mod 3)
//   excl_i  : requesters removed from consideration
//   found_o : some non-excluded requester is asking
//   idx_o   : index of the winner (SEL_R0 when nothing found)
module rr_pick3
    import arb_pkg::*;
(
    input  logic [NREQ_C-1:0] req_i,
    input  sel_t              ptr_i,
    input  logic [NREQ_C-1:0] excl_i,
    output logic              found_o,
    output sel_t              idx_o
);

    logic [NREQ_C-1:0] cand;
    sel_t              pos;

    // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        found_o = 1'b0;
        idx_o   = SEL_R0;
        cand    = req_i & ~excl_i;
        pos     = ptr_i;
        for (int k = 0; k < NREQ_C; k++) begin
            if (!found_o && cand[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
            pos = inc_mod3(pos);
        end
    end

endmodule

// File: rtl/port_arbiter3.sv
// Round-robin arbiter / sequencer for a shared 3-input datapath mux.
// Grants one requester at a time and holds the grant for a multi-beat
// transfer until that requester's last beat is accepted, it drops req
// (abort), or the beat stalls for TIMEOUT cycles.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req[2:0]    : per-requester request (held until last beat accepted)
//   last[2:0]   : per-requester "current beat is final" marker
//   mem_ready   : downstream accepts the presented beat
//   mem_valid   : a beat is presented downstream (req[owner] while busy)
//   sel[1:0]    : datapath mux select, holds its value while idle
//   gnt[2:0]    : one-hot grant to the owner, zero when idle
//   busy        : an owner exists
//   timeout_err : one-cycle pulse after a timeout release
module port_arbiter3
    import arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] last,
    input  logic            mem_ready,
    output logic            mem_valid,
    output sel_t            sel,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            timeout_err
);

    localparam int               CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0]    STALL_MAX = CW'(TIMEOUT - 1);

    arb_state_t      state_q, state_d;
    sel_t            owner_q, owner_d;
    sel_t            ptr_q,   ptr_d;
    logic [CW-1:0]   stall_q, stall_d;
    logic            terr_q,  terr_d;

    logic [NREQ-1:0] owner_oh;
    logic            busy_w, valid_w;
    logic            accept, done, abort, stalled, tmo, release_w;
    sel_t            pick_ptr, pick_idx;
    logic [NREQ-1:0] pick_excl;
    logic            pick_found;

    assign owner_oh  = onehot3(owner_q);
    assign busy_w    = (state_q == GRANT);
    assign valid_w   = busy_w & |(req & owner_oh);
    assign accept    = valid_w & mem_ready;
    assign done      = accept & |(last & owner_oh);
    assign abort     = busy_w & ~valid_w;
    assign stalled   = valid_w & ~mem_ready;
    // An accepted beat is never stalled, so accept always beats timeout.
    assign tmo       = stalled & (stall_q == STALL_MAX);
    assign release_w = done | abort | tmo;

    // On release the search starts after the old owner, so it is picked
    // only when alone. After a completed transfer its req is still high in
    // the accept cycle but is stale, hence the explicit exclusion.
    assign pick_ptr  = busy_w ? inc_mod3(owner_q) : ptr_q;
    assign pick_excl = done ? owner_oh : '0;

    rr_pick3 u_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .excl_i  (pick_excl),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= SEL_R0;
            ptr_q   <= SEL_R0;
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    stall_d = '0;
                end
            end
            GRANT: begin
                if (release_w) begin
                    ptr_d   = inc_mod3(owner_q);
                    stall_d = '0;
                    terr_d  = tmo & ~done;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    stall_d = '0;
                end else if (stalled) begin
                    stall_d = stall_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = busy_w;
        sel         = owner_q;
        gnt         = busy_w ? owner_oh : '0;
        mem_valid   = valid_w;
        timeout_err = terr_q;
    end

endmodule

// File: tb/tb_port_arbiter3.sv
module tb_port_arbiter3;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req, last;
    logic       mem_ready;
    logic       mem_valid, busy, timeout_err;
    logic [1:0] sel;
    logic [2:0] gnt;

    int checks = 0;
    int errors = 0;

    port_arbiter3 #(.NREQ(3), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .last        (last),
        .mem_ready   (mem_ready),
        .mem_valid   (mem_valid),
        .sel         (sel),
        .gnt         (gnt),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [2:0] req;
        logic [2:0] last;
        logic       rdy;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       valid;
        logic       terr;
        logic [1:0] ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input logic [2:0] rq, input logic [2:0] ls, input logic rd,
                       input logic [2:0] g, input logic [1:0] s, input logic b,
                       input logic v, input logic t, input logic [1:0] p);
        vec_t e;
        e.rst = r; e.req = rq; e.last = ls; e.rdy = rd;
        e.gnt = g; e.sel = s; e.busy = b; e.valid = v; e.terr = t; e.ptr = p;
        vecs.push_back(e);
    endtask

    task automatic reset_dut();
        req = 3'b000; last = 3'b000; mem_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        // rst, req, last, rdy | gnt, sel, busy, valid, terr, ptr
        // Single 3-beat burst from requester 1.
        add(1, 3'b010, 3'b000, 1, 3'b000, 2'd0, 0, 0, 0, 2'd0);
        add(0, 3'b010, 3'b000, 1, 3'b010, 2'd1, 1, 1, 0, 2'd0);
        add(0, 3'b010, 3'b000, 1, 3'b010, 2'd1, 1, 1, 0, 2'd0);
        add(0, 3'b010, 3'b010, 1, 3'b010, 2'd1, 1, 1, 0, 2'd0);
        add(0, 3'b000, 3'b000, 1, 3'b000, 2'd1, 0, 0, 0, 2'd2);
        // Contention, 1-beat transfers, zero-bubble handover 0,1,2,0.
        add(1, 3'b111, 3'b111, 1, 3'b000, 2'd0, 0, 0, 0, 2'd0);
        add(0, 3'b111, 3'b111, 1, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b111, 3'b111, 1, 3'b010, 2'd1, 1, 1, 0, 2'd1);
        add(0, 3'b111, 3'b111, 1, 3'b100, 2'd2, 1, 1, 0, 2'd2);
        add(0, 3'b111, 3'b111, 1, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        // Abort by owner 1 with requester 0 waiting; non-owner last ignored.
        add(1, 3'b010, 3'b000, 1, 3'b000, 2'd0, 0, 0, 0, 2'd0);
        add(0, 3'b011, 3'b001, 1, 3'b010, 2'd1, 1, 1, 0, 2'd0);
        add(0, 3'b001, 3'b000, 1, 3'b010, 2'd1, 1, 0, 0, 2'd0);
        add(0, 3'b001, 3'b000, 1, 3'b001, 2'd0, 1, 1, 0, 2'd2);
        // Timeout on owner 2 after 4 stalled cycles, requester 0 takes over.
        add(1, 3'b100, 3'b000, 0, 3'b000, 2'd0, 0, 0, 0, 2'd0);
        add(0, 3'b101, 3'b000, 0, 3'b100, 2'd2, 1, 1, 0, 2'd0);
        add(0, 3'b101, 3'b000, 0, 3'b100, 2'd2, 1, 1, 0, 2'd0);
        add(0, 3'b101, 3'b000, 0, 3'b100, 2'd2, 1, 1, 0, 2'd0);
        add(0, 3'b101, 3'b000, 0, 3'b100, 2'd2, 1, 1, 0, 2'd0);
        add(0, 3'b101, 3'b000, 0, 3'b001, 2'd0, 1, 1, 1, 2'd0);
        add(0, 3'b101, 3'b001, 1, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b100, 3'b100, 1, 3'b100, 2'd2, 1, 1, 0, 2'd1);
        // Stall counter cleared by an accepted beat; accept at TIMEOUT-1 wins.
        add(1, 3'b001, 3'b000, 0, 3'b000, 2'd0, 0, 0, 0, 2'd0);
        add(0, 3'b001, 3'b000, 0, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b001, 3'b000, 0, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b001, 3'b000, 1, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b001, 3'b000, 0, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b001, 3'b000, 0, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b001, 3'b000, 0, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b001, 3'b001, 1, 3'b001, 2'd0, 1, 1, 0, 2'd0);
        add(0, 3'b000, 3'b000, 0, 3'b000, 2'd0, 0, 0, 0, 2'd1);

        // Reset with all requesters asserted.
        rst_n = 1'b0; req = 3'b111; last = 3'b000; mem_ready = 1'b0;
        #3;
        check("rst gnt",   32'(gnt),       32'h0);
        check("rst sel",   32'(sel),       32'h0);
        check("rst busy",  32'(busy),      32'h0);
        check("rst valid", 32'(mem_valid), 32'h0);
        check("rst terr",  32'(timeout_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst idle gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        check("first grant gnt",   32'(gnt),       32'h1);
        check("first grant sel",   32'(sel),       32'h0);
        check("first grant busy",  32'(busy),      32'h1);
        check("first grant valid", 32'(mem_valid), 32'h1);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) reset_dut();
            req       = vecs[i].req;
            last      = vecs[i].last;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d gnt",   i), 32'(gnt),         32'(vecs[i].gnt));
            check($sformatf("v%0d sel",   i), 32'(sel),         32'(vecs[i].sel));
            check($sformatf("v%0d busy",  i), 32'(busy),        32'(vecs[i].busy));
            check($sformatf("v%0d valid", i), 32'(mem_valid),   32'(vecs[i].valid));
            check($sformatf("v%0d terr",  i), 32'(timeout_err), 32'(vecs[i].terr));
            check($sformatf("v%0d ptr",   i), 32'(dut.ptr_q),   32'(vecs[i].ptr));
            @(posedge clk);
            #1;
        end

        // Reset during the second beat of an owner-0 burst, with ptr moved to 2 first.
        reset_dut();
        req = 3'b010; last = 3'b010; mem_ready = 1'b1;
        @(posedge clk); #1;
        check("mid owner1 gnt", 32'(gnt), 32'h2);
        @(posedge clk); #1;
        req = 3'b001; last = 3'b000;
        check("mid idle busy", 32'(busy), 32'h0);
        check("mid ptr before", 32'(dut.ptr_q), 32'h2);
        @(posedge clk); #1;
        check("mid beat1 gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        check("mid beat2 gnt",   32'(gnt),       32'h1);
        check("mid beat2 valid", 32'(mem_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst gnt",   32'(gnt),         32'h0);
        check("mid rst sel",   32'(sel),         32'h0);
        check("mid rst busy",  32'(busy),        32'h0);
        check("mid rst valid", 32'(mem_valid),   32'h0);
        check("mid rst terr",  32'(timeout_err), 32'h0);
        check("mid rst ptr",   32'(dut.ptr_q),   32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
